mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Three-requester arbiter and sequencer for the shared memory port in the datapath. It grants one requester at a time and drives the `select_a`/`select_b` lines of the 3-input port mux, which steers that requester's address and data onto the memory port. It also runs the `mem_valid`/`mem_ready` handshake and releases the port on completion or timeout. It sits between the fetch, load/store and debug requesters and the port mux.

## Interface

**Parameters**
- `TIMEOUT_CYC`, default 16: maximum cycles in BUSY before a forced release. Legal range is 2..65535.

**Ports**
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_a` in 1: request from requester A (fetch). Held until `done_a`.
- `req_b` in 1: request from requester B (load/store). Held until `done_b`.
- `req_c` in 1: request from requester C (debug). Held until `done_c`.
- `gnt_a` out 1: A owns the port. Registered.
- `gnt_b` out 1: B owns the port. Registered.
- `gnt_c` out 1: C owns the port. Registered.
- `done_a` out 1: A's transaction completed this cycle. Combinational, equal to `gnt_a & mem_ready`.
- `done_b` out 1: same as `done_a` for B.
- `done_c` out 1: same as `done_a` for C.
- `select_a` out 1: port-mux select A. Registered, equal to `gnt_a`.
- `select_b` out 1: port-mux select B. Registered, equal to `gnt_b`. When both selects are 0 the mux passes C.
- `mem_valid` out 1: request is valid on the memory port. Registered.
- `mem_ready` in 1: memory accepted and completed the request.
- `err_timeout` out 1: one-cycle registered pulse on a forced release.

## Operation

- **States:** IDLE and BUSY.
- **IDLE:**
  - All `gnt_*` are 0, `mem_valid` is 0, and both selects are 0.
  - If any `req_*` is 1, the arbiter picks a winner per the priority rule.
  - Next edge: BUSY; winner's `gnt` = 1; matching select = 1; `mem_valid` = 1; timeout counter = 0.
- **BUSY:**
  - Grant, selects and `mem_valid` are held stable.
  - All `req_*` inputs are ignored, including a drop of the owner's own request; the transaction runs to completion.
  - If `mem_ready` = 1: `done_x` pulses that cycle and the next edge goes to IDLE.
  - If `mem_ready` = 0 and counter = `TIMEOUT_CYC`-1: the next edge goes to IDLE, `err_timeout` = 1 for one cycle, and `done_x` is not asserted.
  - Otherwise the counter increments. The counter width is `$clog2(TIMEOUT_CYC)`.
- **One-hot invariant:** `gnt_a`, `gnt_b`, `gnt_c` are one-hot or all zero; `select_a` and `select_b` are never both 1.
- **Priority rule:** set by the configuration macro (see Configuration).
- **Reset:** synchronous and may arrive in any state, including mid-transaction. On the next edge:
  - state = IDLE;
  - all `gnt`, selects, `mem_valid` and `err_timeout` = 0;
  - round-robin pointer = A;
  - counter = 0.

## Timing

- **Grant latency:** 1 cycle. A request sampled in IDLE at edge N gives `gnt`/`mem_valid` high after edge N.
- **Transaction length:** minimum 2 cycles per transaction (1 BUSY cycle plus 1 IDLE cycle). Back-to-back grants are always separated by exactly one IDLE cycle.
- **Completion:** `mem_ready` is sampled only in BUSY. `done_x` is the same cycle as `mem_ready`. `gnt` falls after the following edge.
- **Timeout:** a forced release occurs after exactly `TIMEOUT_CYC` BUSY cycles with no `mem_ready`. `err_timeout` is high during the first IDLE cycle after the release.
- **Collisions:**
  - `mem_ready` and timeout in the same cycle: completion wins; no error.
  - Simultaneous requests: resolved in one IDLE cycle; no starvation when round-robin is enabled.

## Configuration

Macro `MEM_PORT_ARB_ROUND_ROBIN_EN`:
- **Defined:**
  - Rotating priority. A 2-bit pointer names the highest-priority requester, with order A→B→C→A.
  - On each grant the pointer moves to the requester after the winner.
  - Reset value of the pointer: A.
- **Undefined:**
  - Fixed priority A > B > C.
  - The pointer logic is absent.
  - Starvation of C under continuous A/B requests is accepted.

## Test plan

- **Reset:** hold `rst` 2 cycles with all `req` = 1 → all outputs 0; release → `gnt_a` = 1, `select_a` = 1 and `mem_valid` = 1 one cycle later.
- **Single request:** `req_b` only, `mem_ready` 3 cycles after grant → `select_b` = 1 and `mem_valid` = 1 for exactly 3 cycles; `done_b` pulses 1 cycle; the next grant is possible 1 cycle after that.
- **Contention:** all three requests held, `mem_ready` = 1 every BUSY cycle.
  - Round-robin defined → grant order A, B, C, A, with grants 2 cycles apart.
  - Round-robin undefined → A, A, A.
- **Timeout:** `TIMEOUT_CYC` = 4, `req_c`, `mem_ready` held 0 → BUSY lasts 4 cycles, `err_timeout` is a single pulse, no `done_c`, and the arbiter returns to IDLE.
- **Ready on the timeout cycle:** `mem_ready` = 1 on the 4th BUSY cycle with `TIMEOUT_CYC` = 4 → `done` pulses and `err_timeout` stays 0.
- **Mid-transaction disturbances:**
  - `req_a` dropped while granted → `gnt_a` holds until `mem_ready`.
  - `rst` asserted in BUSY → all outputs 0 on the next edge and the pointer returns to A.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter and handshake sequencer for the shared memory port (fetch, load/store, debug).
// Define MEM_PORT_ARB_ROUND_ROBIN_EN for rotating priority; fixed A > B > C otherwise.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic req_c,
  output logic gnt_a,
  output logic gnt_b,
  output logic gnt_c,
  output logic done_a,
  output logic done_b,
  output logic done_c,
  output logic select_a,
  output logic select_b,
  output logic mem_valid,
  input  logic mem_ready,
  output logic err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       gnt_r, gnt_s;
  logic             sel_a_r, sel_a_s;
  logic             sel_b_r, sel_b_s;
  logic             mem_valid_r, mem_valid_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       req_s;
  logic [2:0]       win_s;

  // Fixed priority A > B > C; result is one-hot or zero.
  function automatic logic [2:0] pick_fixed(input logic [2:0] req);
    logic [2:0] win;
    if (req[0]) begin
      win = 3'b001;
    end else if (req[1]) begin
      win = 3'b010;
    end else if (req[2]) begin
      win = 3'b100;
    end else begin
      win = 3'b000;
    end
    return win;
  endfunction

`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_r, ptr_s;

  // Rotating priority starting at the requester named by ptr (0=A, 1=B, 2=C).
  function automatic logic [2:0] pick_rr(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] win;
    case (ptr)
      2'd1: begin
        if (req[1]) begin
          win = 3'b010;
        end else if (req[2]) begin
          win = 3'b100;
        end else if (req[0]) begin
          win = 3'b001;
        end else begin
          win = 3'b000;
        end
      end
      2'd2: begin
        if (req[2]) begin
          win = 3'b100;
        end else if (req[0]) begin
          win = 3'b001;
        end else if (req[1]) begin
          win = 3'b010;
        end else begin
          win = 3'b000;
        end
      end
      default: win = pick_fixed(req);
    endcase
    return win;
  endfunction

  // Pointer moves to the requester after the winner.
  function automatic logic [1:0] next_ptr(input logic [2:0] win, input logic [1:0] ptr);
    logic [1:0] nxt;
    case (win)
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b100:  nxt = 2'd0;
      default: nxt = ptr;
    endcase
    return nxt;
  endfunction
`endif

  assign req_s = {req_c, req_b, req_a};

  // Winner selection for the next grant.
  always_comb begin
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    win_s = pick_rr(req_s, ptr_r);
`else
    win_s = pick_fixed(req_s);
`endif
  end

  // Next-state and next-output logic for the IDLE/BUSY sequencer.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    sel_a_s     = sel_a_r;
    sel_b_s     = sel_b_r;
    mem_valid_s = mem_valid_r;
    err_s       = 1'b0;
    cnt_s       = cnt_r;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    ptr_s       = ptr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        gnt_s       = 3'b000;
        sel_a_s     = 1'b0;
        sel_b_s     = 1'b0;
        mem_valid_s = 1'b0;
        cnt_s       = CNT_ZERO;
        if (|req_s) begin
          state_s     = ST_BUSY;
          gnt_s       = win_s;
          sel_a_s     = win_s[0];
          sel_b_s     = win_s[1];
          mem_valid_s = 1'b1;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
          ptr_s       = next_ptr(win_s, ptr_r);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Completion is checked first so ready on the last cycle is not an error.
        if (mem_ready) begin
          state_s     = ST_IDLE;
          gnt_s       = 3'b000;
          sel_a_s     = 1'b0;
          sel_b_s     = 1'b0;
          mem_valid_s = 1'b0;
          cnt_s       = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s     = ST_IDLE;
          gnt_s       = 3'b000;
          sel_a_s     = 1'b0;
          sel_b_s     = 1'b0;
          mem_valid_s = 1'b0;
          cnt_s       = CNT_ZERO;
          err_s       = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = 3'b000;
        sel_a_s     = 1'b0;
        sel_b_s     = 1'b0;
        mem_valid_s = 1'b0;
        cnt_s       = CNT_ZERO;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      gnt_r       <= 3'b000;
      sel_a_r     <= 1'b0;
      sel_b_r     <= 1'b0;
      mem_valid_r <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= CNT_ZERO;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
      ptr_r       <= 2'd0;
`endif
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      sel_a_r     <= sel_a_s;
      sel_b_r     <= sel_b_s;
      mem_valid_r <= mem_valid_s;
      err_r       <= err_s;
      cnt_r       <= cnt_s;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
      ptr_r       <= ptr_s;
`endif
    end
  end

  assign gnt_a       = gnt_r[0];
  assign gnt_b       = gnt_r[1];
  assign gnt_c       = gnt_r[2];
  assign select_a    = sel_a_r;
  assign select_b    = sel_b_r;
  assign mem_valid   = mem_valid_r;
  assign err_timeout = err_r;
  assign done_a      = gnt_r[0] & mem_ready;
  assign done_b      = gnt_r[1] & mem_ready;
  assign done_c      = gnt_r[2] & mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues timed grant/done/timeout
// events; a negedge monitor pops and compares them and checks the one-hot/select invariants.
module tb_mem_port_arbiter;

  localparam int EV_GNT  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_TMO  = 2;

  typedef struct {
    int kind;
    int id;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic req_a, req_b, req_c;
  logic gnt_a, gnt_b, gnt_c;
  logic done_a, done_b, done_c;
  logic select_a, select_b;
  logic mem_valid;
  logic mem_ready;
  logic err_timeout;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [2:0] prev_g = 3'b000;
  logic [2:0] mon_g;
  logic [2:0] mon_d;
  int   cont_ids[4];

  mem_port_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .done_a(done_a), .done_b(done_b), .done_c(done_c),
    .select_a(select_a), .select_b(select_b),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int onehot_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic push(input int kind, input int id, input int at);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic sb_event(input int kind, input int id);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d id %0d at cycle %0d, expected none", kind, id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.id != id || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d id %0d cycle %0d, expected kind %0d id %0d cycle %0d",
                 kind, id, cyc, e.kind, e.id, e.cyc);
      end
    end
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: invariants every cycle, scoreboard events on grant start, done and timeout.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_g = {gnt_c, gnt_b, gnt_a};
      mon_d = {done_c, done_b, done_a};
      checks++;
      if (!$onehot0(mon_g) || select_a !== mon_g[0] || select_b !== mon_g[1] ||
          mem_valid !== (|mon_g) || (select_a && select_b)) begin
        errors++;
        $display("FAIL invariant: gnt %b sel_a %b sel_b %b mem_valid %b at cycle %0d, expected one-hot gnt mirrored on selects/valid",
                 mon_g, select_a, select_b, mem_valid, cyc);
      end
      if (mon_g != 3'b000 && prev_g == 3'b000) sb_event(EV_GNT, onehot_idx(mon_g));
      if (mon_d != 3'b000) sb_event(EV_DONE, onehot_idx(mon_d));
      if (err_timeout) sb_event(EV_TMO, 0);
      prev_g = mon_g;
    end
  end

  initial begin
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    cont_ids = '{0, 1, 2, 0};
`else
    cont_ids = '{0, 0, 0, 0};
`endif
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; req_c = 1'b1; mem_ready = 1'b0;

    // Reset held two cycles with all requests pending.
    to_cyc(2);
    chk("reset_gnt", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd0);
    chk("reset_sel_valid", {29'd0, select_a, select_b, mem_valid}, 32'd0);
    chk("reset_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(EV_GNT,  cont_ids[i], 3 + 2 * i);
      push(EV_DONE, cont_ids[i], 3 + 2 * i);
    end

    // Contention ends; B alone, ready on its third BUSY cycle.
    to_cyc(9);  req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    to_cyc(10); mem_ready = 1'b0; req_b = 1'b1;
    push(EV_GNT, 1, 11); push(EV_DONE, 1, 13);
    to_cyc(13); mem_ready = 1'b1; req_b = 1'b0; req_a = 1'b1;
    push(EV_GNT, 0, 15);
    to_cyc(14); mem_ready = 1'b0;
    chk("b_release_idle", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd0);

    // A drops its request while owning the port.
    to_cyc(15); req_a = 1'b0;
    to_cyc(16); chk("a_hold_after_drop", {31'd0, gnt_a}, 32'd1);
    to_cyc(17); mem_ready = 1'b1; push(EV_DONE, 0, 17);

    // C with no ready: forced release after four BUSY cycles.
    to_cyc(18); mem_ready = 1'b0; req_c = 1'b1;
    push(EV_GNT, 2, 19); push(EV_TMO, 0, 23);
    to_cyc(19); req_c = 1'b0;
    to_cyc(22); chk("c_busy_last", {31'd0, gnt_c}, 32'd1);
    to_cyc(23);
    chk("c_released", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd0);
    chk("c_err_pulse", {31'd0, err_timeout}, 32'd1);
    to_cyc(24);
    chk("err_single", {31'd0, err_timeout}, 32'd0);

    // Ready arrives on the last allowed BUSY cycle: completion, no error.
    req_b = 1'b1; push(EV_GNT, 1, 25); push(EV_DONE, 1, 28);
    to_cyc(25); req_b = 1'b0;
    to_cyc(28); mem_ready = 1'b1;
    to_cyc(29); mem_ready = 1'b0;
    chk("rdy_on_last_no_err", {31'd0, err_timeout}, 32'd0);

    // Reset mid-transaction; pointer must be back at A afterwards.
    req_b = 1'b1; push(EV_GNT, 1, 30);
    to_cyc(30); rst = 1'b1; req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
    to_cyc(31);
    chk("mid_reset_gnt", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd0);
    chk("mid_reset_valid_err", {30'd0, mem_valid, err_timeout}, 32'd0);
    rst = 1'b0; mem_ready = 1'b1;
    push(EV_GNT, 0, 32); push(EV_DONE, 0, 32);
    to_cyc(32); req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    to_cyc(33); mem_ready = 1'b0;

    to_cyc(36);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
